// File: rtl/prog_mem.sv
// Segmented program memory: a clear sweep, a streaming segment loader with overflow
// detection and a registered read port with one cycle of latency.
module prog_mem #(
   parameter int DATA_W    = 8,
   parameter int SEG_COUNT = 4,
   parameter int SEG_DEPTH = 16,
   localparam int SEG_W    = $clog2(SEG_COUNT),
   localparam int OFF_W    = $clog2(SEG_DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rd_en,
   input  logic [SEG_W-1:0]  rd_seg,
   input  logic [OFF_W-1:0]  rd_off,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   input  logic              clr_start,
   input  logic              ld_start,
   input  logic [SEG_W-1:0]  ld_seg,
   input  logic              ld_valid,
   input  logic [DATA_W-1:0] ld_data,
   input  logic              ld_last,
   output logic              ld_ready,
   output logic              busy,
   output logic              ld_err
);

   localparam int ADDR_W = SEG_W + OFF_W;
   localparam int DEPTH  = SEG_COUNT * SEG_DEPTH;

   typedef enum logic [1:0] {CLEAR, IDLE, LOAD} state_t;

   state_t              state_reg;
   logic [ADDR_W-1:0]   ptr_reg;
   logic [SEG_W-1:0]    seg_reg;
   logic [OFF_W-1:0]    off_reg;
   logic                busy_reg;
   logic                ld_ready_reg;
   logic                ld_err_reg;
   logic [DATA_W-1:0]   rd_data_reg;
   logic                rd_valid_reg;

   logic [DATA_W-1:0]   mem [DEPTH];

   logic                wr_en;
   logic [ADDR_W-1:0]   wr_addr;
   logic [DATA_W-1:0]   wr_data;

   // Single write port, owned by the FSM; no writes while reset is held.
   always_comb begin
      wr_en   = 1'b0;
      wr_addr = ptr_reg;
      wr_data = '0;
      if (rst_n) begin
         case (state_reg)
            CLEAR: wr_en = 1'b1;
            LOAD: begin
               if (ld_valid) begin
                  wr_en   = 1'b1;
                  wr_addr = {seg_reg, off_reg};
                  wr_data = ld_data;
               end
            end
            default: wr_en = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_addr] <= wr_data;
   end

   // Non-blocking read of the array gives the pre-write word on a same-address collision.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_data_reg  <= '0;
         rd_valid_reg <= 1'b0;
      end else begin
         rd_valid_reg <= rd_en;
         if (rd_en)
            rd_data_reg <= mem[{rd_seg, rd_off}];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg    <= CLEAR;
         ptr_reg      <= '0;
         seg_reg      <= '0;
         off_reg      <= '0;
         busy_reg     <= 1'b1;
         ld_ready_reg <= 1'b0;
         ld_err_reg   <= 1'b0;
      end else begin
         case (state_reg)
            CLEAR: begin
               ptr_reg <= ptr_reg + ADDR_W'(1);
               if (ptr_reg == ADDR_W'(DEPTH - 1)) begin
                  state_reg <= IDLE;
                  busy_reg  <= 1'b0;
               end
            end
            IDLE: begin
               if (clr_start) begin
                  state_reg <= CLEAR;
                  ptr_reg   <= '0;
                  busy_reg  <= 1'b1;
               end else if (ld_start) begin
                  state_reg    <= LOAD;
                  seg_reg      <= ld_seg;
                  off_reg      <= '0;
                  ld_err_reg   <= 1'b0;
                  busy_reg     <= 1'b1;
                  ld_ready_reg <= 1'b1;
               end
            end
            LOAD: begin
               if (ld_valid) begin
                  off_reg <= off_reg + OFF_W'(1);
                  if (ld_last) begin
                     state_reg    <= IDLE;
                     busy_reg     <= 1'b0;
                     ld_ready_reg <= 1'b0;
                  end else if (off_reg == {OFF_W{1'b1}}) begin
                     // Segment full without a last marker: stop rather than spill over.
                     state_reg    <= IDLE;
                     busy_reg     <= 1'b0;
                     ld_ready_reg <= 1'b0;
                     ld_err_reg   <= 1'b1;
                  end
               end
            end
            default: begin
               state_reg    <= CLEAR;
               ptr_reg      <= '0;
               busy_reg     <= 1'b1;
               ld_ready_reg <= 1'b0;
            end
         endcase
      end
   end

   assign rd_data  = rd_data_reg;
   assign rd_valid = rd_valid_reg;
   assign ld_ready = ld_ready_reg;
   assign busy     = busy_reg;
   assign ld_err   = ld_err_reg;

endmodule
